// File: rtl/nn_fixed_pkg.sv
// Shared fixed-point definitions for the NN datapath blocks: default Q format,
// index sizing helper and the sequencer state encoding.
package nn_fixed_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_FRAC_W = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   function automatic int index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fixed_mult_lane.sv
// One signed DATA_W x DATA_W fixed-point multiply lane with result narrowing.
// `define SATURATE_EN selects clamping (and exposes sat); otherwise sign-preserving truncation.
module fixed_mult_lane
   import nn_fixed_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] res
`ifdef SATURATE_EN
   ,
   output logic              sat
`endif
);

   logic signed [2*DATA_W-1:0] prod;

   assign prod = $signed(a) * $signed(b);

`ifdef SATURATE_EN
   localparam logic signed [2*DATA_W-1:0] MAX_V = (2*DATA_W)'(2**(DATA_W-1) - 1);
   localparam logic signed [2*DATA_W-1:0] MIN_V = ~MAX_V;

   logic signed [2*DATA_W-1:0] shifted;

   assign shifted = prod >>> FRAC_W;

   always_comb begin
      res = shifted[DATA_W-1:0];
      sat = 1'b0;
      if (shifted > MAX_V) begin
         res = MAX_V[DATA_W-1:0];
         sat = 1'b1;
      end else if (shifted < MIN_V) begin
         res = MIN_V[DATA_W-1:0];
         sat = 1'b1;
      end
   end
`else
   // Keep the product sign, drop the overflow bits between sign and the kept magnitude.
   assign res = {prod[2*DATA_W-1], (DATA_W-1)'(prod >>> FRAC_W)};
`endif

endmodule

// File: rtl/matrix_scalar_mult_seq.sv
// Sequential matrix-by-scalar multiplier: LANES elements per compute cycle.
// `define SATURATE_EN enables clamping and the sticky sat_flag output.
//
// state   | meaning
// IDLE    | waiting for a matrix, in_ready high
// COMPUTE | lanes write results, C cycles
// DONE    | out_mat complete, out_valid high until out_ready
module matrix_scalar_mult_seq
   import nn_fixed_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int FRAC_W = DEF_FRAC_W,
   parameter int ROWS   = 3,
   parameter int COLS   = 2,
   parameter int LANES  = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [ROWS*COLS*DATA_W-1:0]   in_mat,
   input  logic [DATA_W-1:0]             in_scalar,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [ROWS*COLS*DATA_W-1:0]   out_mat,
   output logic                          busy
`ifdef SATURATE_EN
   ,
   output logic                          sat_flag
`endif
);

   localparam int N     = ROWS * COLS;
   localparam int C     = (N + LANES - 1) / LANES;
   localparam int IDX_W = index_width(N);
   localparam int CNT_W = index_width(C);

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [CNT_W-1:0]    cnt;
   logic [N*DATA_W-1:0] mat_q;
   logic [DATA_W-1:0]   scalar_q;
   logic [DATA_W-1:0]   res_q    [N];
   logic [DATA_W-1:0]   lane_a   [LANES];
   logic [DATA_W-1:0]   lane_res [LANES];
   logic [LANES-1:0]    lane_en;
   logic                accept;

   assign accept = in_valid && in_ready;

   // Lane l works on element idx+l; lanes past the last element stay gated.
   always_comb begin
      lane_en = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_a[l]  = '0;
         lane_en[l] = (int'(idx) + l) < N;
         for (int e = 0; e < N; e++) begin
            if (int'(idx) + l == e) lane_a[l] = mat_q[(N-1-e)*DATA_W +: DATA_W];
         end
      end
   end

`ifdef SATURATE_EN
   logic [LANES-1:0] lane_sat;
   logic             sat_pend;
`endif

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      fixed_mult_lane #(
         .DATA_W (DATA_W),
         .FRAC_W (FRAC_W)
      ) u_lane (
         .a   (lane_a[l]),
         .b   (scalar_q),
         .res (lane_res[l])
`ifdef SATURATE_EN
         ,
         .sat (lane_sat[l])
`endif
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cnt counts remaining compute cycles down to terminal count zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx      <= '0;
         cnt      <= '0;
         mat_q    <= '0;
         scalar_q <= '0;
         for (int e = 0; e < N; e++) res_q[e] <= '0;
      end else if (accept) begin
         mat_q    <= in_mat;
         scalar_q <= in_scalar;
         idx      <= '0;
         cnt      <= CNT_W'(C - 1);
      end else if (state == COMPUTE) begin
         idx <= idx + IDX_W'(LANES);
         cnt <= cnt - 1'b1;
         for (int e = 0; e < N; e++) begin
            for (int l = 0; l < LANES; l++) begin
               if (lane_en[l] && (int'(idx) + l == e)) res_q[e] <= lane_res[l];
            end
         end
      end
   end

`ifdef SATURATE_EN
   // Clamp events accumulate over the pass; the flag is published on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_pend <= 1'b0;
         sat_flag <= 1'b0;
      end else if (accept) begin
         sat_pend <= 1'b0;
         sat_flag <= 1'b0;
      end else if (state == COMPUTE) begin
         sat_pend <= sat_pend | (|(lane_sat & lane_en));
         if (cnt == '0) sat_flag <= sat_pend | (|(lane_sat & lane_en));
      end
   end
`endif

   always_comb begin
      out_mat = '0;
      for (int e = 0; e < N; e++) out_mat[(N-1-e)*DATA_W +: DATA_W] = res_q[e];
   end

endmodule
